// File: rtl/adc_threshold_event_gen.sv
// adc_threshold_event_gen
//   Turns the raw modular-ADC sample stream into per-channel threshold-crossing
//   events with high/low hysteresis and a consecutive-sample debounce.
//
// Build option:
//   THRESH_EVT_FIFO_EN - when defined, events are queued in a FIFO_DEPTH-entry
//   FIFO and handed out with a valid/ready handshake; when undefined, each event
//   is a registered one-cycle pulse and threshold_ready is ignored.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   enable              detection enable; 0 clears all debounce counters
//   sample_valid/_channel/_data   incoming ADC sample
//   thr_high, thr_low   packed per-channel thresholds, channel k at [k*DATA_W +: DATA_W]
//   threshold_ready     consumer accept (FIFO build only)
//   threshold_valid/_channel/_data  outgoing event {channel, new state}
//   channel_state       debounced state per channel (1 = above)
//   overflow            sticky: an event was dropped on a full FIFO
module adc_threshold_event_gen #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic [4:0]               sample_channel,
  input  logic [DATA_W-1:0]        sample_data,
  input  logic [NUM_CH*DATA_W-1:0] thr_high,
  input  logic [NUM_CH*DATA_W-1:0] thr_low,
  input  logic                     threshold_ready,
  output logic                     threshold_valid,
  output logic [4:0]               threshold_channel,
  output logic                     threshold_data,
  output logic [NUM_CH-1:0]        channel_state,
  output logic                     overflow
);

  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

  logic [NUM_CH-1:0] state_q, state_d;
  logic [CntW-1:0]   cnt_q [NUM_CH];
  logic [CntW-1:0]   cnt_d [NUM_CH];
  logic              accept;
  logic              qualify;
  logic              evt_valid;
  logic [4:0]        evt_ch;
  logic              evt_data;

  // Out-of-range channel IDs are ignored entirely.
  assign accept = sample_valid && enable && ({1'b0, sample_channel} < 6'(NUM_CH));

  always_comb begin
    state_d   = state_q;
    qualify   = 1'b0;
    evt_valid = 1'b0;
    evt_ch    = '0;
    evt_data  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = enable ? cnt_q[k] : '0;
      if (accept && (sample_channel == 5'(k))) begin
        // Below looks for an upward crossing of thr_high, above for a
        // downward crossing of thr_low; both comparisons are strict.
        qualify = state_q[k] ? (sample_data < thr_low[k*DATA_W +: DATA_W])
                             : (sample_data > thr_high[k*DATA_W +: DATA_W]);
        if (qualify) begin
          if (cnt_q[k] == CntLast) begin
            state_d[k] = ~state_q[k];
            cnt_d[k]   = '0;
            evt_valid  = 1'b1;
            evt_ch     = 5'(k);
            evt_data   = ~state_q[k];
          end else begin
            cnt_d[k] = cnt_q[k] + CntW'(1);
          end
        end else begin
          cnt_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign channel_state = state_q;

`ifdef THRESH_EVT_FIFO_EN
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FcntW = $clog2(FIFO_DEPTH + 1);

  logic [5:0]       mem_q [FIFO_DEPTH];   // {channel, data}
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic             ovf_q;
  logic             full, pop, do_push, drop;

  assign full    = (fcnt_q == FcntW'(FIFO_DEPTH));
  assign pop     = (fcnt_q != '0) && threshold_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = evt_valid && (!full || pop);
  assign drop    = evt_valid && full && !pop;

  always_comb begin
    fcnt_d = fcnt_q;
    unique case ({do_push, pop})
      2'b10:   fcnt_d = fcnt_q + FcntW'(1);
      2'b01:   fcnt_d = fcnt_q - FcntW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (drop)    ovf_q    <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {evt_ch, evt_data};
  end

  assign threshold_valid   = (fcnt_q != '0);
  assign threshold_channel = threshold_valid ? mem_q[rd_ptr_q][5:1] : 5'd0;
  assign threshold_data    = threshold_valid ? mem_q[rd_ptr_q][0]   : 1'b0;
  assign overflow          = ovf_q;
`else
  logic       valid_q;
  logic [4:0] ch_q;
  logic       data_q;
  logic       unused_ready;

  assign unused_ready = threshold_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      data_q  <= 1'b0;
    end else begin
      valid_q <= evt_valid;
      if (evt_valid) begin
        ch_q   <= evt_ch;
        data_q <= evt_data;
      end
    end
  end

  assign threshold_valid   = valid_q;
  assign threshold_channel = ch_q;
  assign threshold_data    = data_q;
  assign overflow          = 1'b0;
`endif

endmodule

// File: tb/tb_adc_threshold_event_gen.sv
// Scoreboard bench for adc_threshold_event_gen. Stimulus pushes hand-computed
// expected events; a negedge monitor pops and compares whenever an event is
// presented (and, in the FIFO build, accepted).
module tb_adc_threshold_event_gen;

`ifdef THRESH_EVT_FIFO_EN
  localparam int unsigned Deb = 1;
`else
  localparam int unsigned Deb = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic [4:0]  sample_channel = '0;
  logic [11:0] sample_data = '0;
  logic [35:0] thr_high = {12'h400, 12'h800, 12'h800};
  logic [35:0] thr_low  = {12'h300, 12'h700, 12'h700};
  logic        threshold_ready = 1'b0;
  logic        threshold_valid;
  logic [4:0]  threshold_channel;
  logic        threshold_data;
  logic [2:0]  channel_state;
  logic        overflow;

  adc_threshold_event_gen #(
    .NUM_CH(3), .DATA_W(12), .DEBOUNCE(Deb), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .sample_valid(sample_valid), .sample_channel(sample_channel),
    .sample_data(sample_data), .thr_high(thr_high), .thr_low(thr_low),
    .threshold_ready(threshold_ready), .threshold_valid(threshold_valid),
    .threshold_channel(threshold_channel), .threshold_data(threshold_data),
    .channel_state(channel_state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ch;
    logic       d;
    int         cyc;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: an event counts as delivered when valid (and ready, if queued).
  always @(negedge clk) begin
    evt_t e;
`ifdef THRESH_EVT_FIFO_EN
    if (reset_n && threshold_valid && threshold_ready) begin
`else
    if (reset_n && threshold_valid) begin
`endif
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got ch=%0d data=%0d, expected no event",
                 threshold_channel, threshold_data);
      end else begin
        e = exp_q.pop_front();
        chk("evt_channel", int'(threshold_channel), int'(e.ch));
        chk("evt_data", int'(threshold_data), int'(e.d));
`ifndef THRESH_EVT_FIFO_EN
        chk("evt_cycle", cyc, e.cyc);
`endif
      end
    end
  end

  // One sample per call; evt/ed are the hand-computed expected event.
  task automatic send(input logic [4:0] ch, input logic [11:0] d,
                      input bit evt, input bit ed);
    evt_t e;
    sample_valid   = 1'b1;
    sample_channel = ch;
    sample_data    = d;
    if (evt) begin
      e.ch  = ch;
      e.d   = ed;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic [4:0] ch, input logic [11:0] d, input int n);
    for (int i = 0; i < n; i++) send(ch, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    chk("rst_valid", int'(threshold_valid), 0);
    chk("rst_channel", int'(threshold_channel), 0);
    chk("rst_data", int'(threshold_data), 0);
    chk("rst_state", int'(channel_state), 0);
    chk("rst_overflow", int'(overflow), 0);

`ifdef THRESH_EVT_FIFO_EN
    // Five crossings with ready low: four queued, the fifth dropped.
    send(5'd0, 12'h900, 1'b1, 1'b1);
    send(5'd0, 12'h100, 1'b1, 1'b0);
    send(5'd0, 12'h900, 1'b1, 1'b1);
    send(5'd1, 12'h900, 1'b1, 1'b1);
    send(5'd1, 12'h100, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_state", int'(channel_state), 3'b001);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", int'(threshold_valid), 1);
    chk("hold_channel", int'(threshold_channel), 0);
    chk("hold_data", int'(threshold_data), 1);
    // Drain: one event per cycle, so the queue is empty after four edges.
    threshold_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_valid", int'(threshold_valid), 0);
    chk("drain_count", exp_q.size(), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Reset with two events queued discards them and clears overflow.
    threshold_ready = 1'b0;
    send(5'd0, 12'h100, 1'b1, 1'b0);
    send(5'd1, 12'h900, 1'b1, 1'b1);
    do_reset(1);
    chk("rst2_valid", int'(threshold_valid), 0);
    chk("rst2_overflow", int'(overflow), 0);
    chk("rst2_state", int'(channel_state), 0);

    // Fill the queue, then push and pop together while full: no drop.
    send(5'd0, 12'h900, 1'b1, 1'b1);
    send(5'd0, 12'h100, 1'b1, 1'b0);
    send(5'd1, 12'h900, 1'b1, 1'b1);
    send(5'd1, 12'h100, 1'b1, 1'b0);
    threshold_ready = 1'b1;
    send(5'd2, 12'h500, 1'b1, 1'b1);
    chk("full_pushpop_ovf", int'(overflow), 0);
    chk("full_pushpop_state", int'(channel_state), 3'b100);
    wait_drain("full_pushpop_drain");
`else
    // Equal to thr_high does not qualify; four above it raise an event.
    send_n(5'd1, 12'h800, 4);
    send_n(5'd1, 12'h801, 3);
    send(5'd1, 12'h801, 1'b1, 1'b1);
    chk("rise_state", int'(channel_state), 3'b010);

    // Hysteresis band holds the state; four below thr_low clear it.
    send_n(5'd1, 12'h750, 10);
    send_n(5'd1, 12'h6FF, 3);
    send(5'd1, 12'h6FF, 1'b1, 1'b0);
    chk("fall_state", int'(channel_state), 3'b000);

    // A non-qualifying sample restarts the debounce count.
    send_n(5'd0, 12'h900, 2);
    send_n(5'd0, 12'h100, 1);
    send_n(5'd0, 12'h900, 3);
    send(5'd0, 12'h900, 1'b1, 1'b1);
    chk("debounce_state", int'(channel_state), 3'b001);

    // Out-of-range channels are ignored.
    send_n(5'd5, 12'hFFF, 4);
    send_n(5'd3, 12'hFFF, 4);
    chk("badch_state", int'(channel_state), 3'b001);

    // enable=0 clears counters and suppresses events.
    send_n(5'd2, 12'h500, 3);
    enable = 1'b0;
    send_n(5'd2, 12'h500, 2);
    enable = 1'b1;
    chk("disable_state", int'(channel_state), 3'b001);
    send_n(5'd2, 12'h500, 3);
    send(5'd2, 12'h500, 1'b1, 1'b1);
    chk("reenable_state", int'(channel_state), 3'b101);

    // Interleaved channels keep independent counters.
    for (int i = 0; i < 4; i++) begin
      send(5'd0, 12'h100, i == 3, 1'b0);
      send(5'd2, 12'h200, i == 3, 1'b0);
    end
    chk("interleave_state", int'(channel_state), 3'b000);

    // Reset mid-debounce: a new crossing needs the full count again.
    send_n(5'd0, 12'h900, 3);
    do_reset(1);
    chk("rst2_valid", int'(threshold_valid), 0);
    chk("rst2_overflow", int'(overflow), 0);
    send_n(5'd0, 12'h900, 3);
    chk("rst2_state", int'(channel_state), 3'b000);
    send(5'd0, 12'h900, 1'b1, 1'b1);
    chk("post_rst_state", int'(channel_state), 3'b001);
    wait_drain("final_drain");
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
